// File: rtl/exec_sequencer_if.sv
// Signal bundle between the exec sequencer and its decoder, PC, register file and data memory.
// With PERF_COUNT_EN defined the bundle also carries the CycleCnt/InstCnt counters.
interface exec_sequencer_if;
    logic Start;
    logic RWrite;
    logic AWrite;
    logic Halt;
    logic Branch;
    logic ReadMem;
    logic WriteMem;
    logic BranchTaken;
    logic MemRdy;
    logic PCClr;
    logic IRLoad;
    logic PCInc;
    logic PCLoad;
    logic AccWE;
    logic RegWE;
    logic MemReq;
    logic MemWe;
    logic Busy;
    logic Ack;
    logic Err;
`ifdef PERF_COUNT_EN
    logic [15:0] CycleCnt;
    logic [15:0] InstCnt;
`endif

    modport master (
        input  Start, RWrite, AWrite, Halt, Branch, ReadMem, WriteMem, BranchTaken, MemRdy,
        output PCClr, IRLoad, PCInc, PCLoad, AccWE, RegWE, MemReq, MemWe, Busy, Ack, Err
`ifdef PERF_COUNT_EN
        , output CycleCnt, InstCnt
`endif
    );

    modport slave (
        output Start, RWrite, AWrite, Halt, Branch, ReadMem, WriteMem, BranchTaken, MemRdy,
        input  PCClr, IRLoad, PCInc, PCLoad, AccWE, RegWE, MemReq, MemWe, Busy, Ack, Err
`ifdef PERF_COUNT_EN
        , input CycleCnt, InstCnt
`endif
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer for the accumulator CPU with a timed memory handshake.
// Optional PERF_COUNT_EN adds saturating cycle and instruction counters.
module exec_sequencer #(
    parameter int MEM_TO = 16,
    parameter int TO_W   = 5
) (
    input logic Clk,
    input logic Reset,
    exec_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALTED, S_ERR
    } state_t;

    state_t          state, nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic pc_clr, ir_load, pc_inc, pc_load, acc_we, reg_we, mem_req, mem_we;
    logic busy, ack, err, inst_evt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs are held low for the whole Reset assertion, including the Mealy PCClr.
    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        pc_clr   = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        acc_we   = 1'b0;
        reg_we   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        ack      = 1'b0;
        err      = 1'b0;
        inst_evt = 1'b0;
        if (!Reset) begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        pc_clr = 1'b1;
                        nxt    = S_FETCH;
                    end
                end
                S_FETCH: begin
                    busy    = 1'b1;
                    ir_load = 1'b1;
                    nxt     = S_EXEC;
                end
                S_EXEC: begin
                    busy = 1'b1;
                    if (bus.Halt) begin
                        nxt      = S_HALTED;
                        inst_evt = 1'b1;
                    end else if (bus.ReadMem || bus.WriteMem) begin
                        nxt     = S_MEM;
                        cnt_nxt = '0;
                    end else begin
                        nxt = S_WB;
                    end
                end
                S_MEM: begin
                    busy    = 1'b1;
                    mem_req = 1'b1;
                    mem_we  = bus.WriteMem;
                    if (bus.MemRdy)
                        nxt = S_WB;
                    else if (cnt == TO_W'(MEM_TO - 1))
                        nxt = S_ERR;
                    else
                        cnt_nxt = cnt + TO_W'(1);
                end
                S_WB: begin
                    busy     = 1'b1;
                    inst_evt = 1'b1;
                    acc_we   = bus.AWrite;
                    reg_we   = bus.RWrite;
                    if (bus.Branch && bus.BranchTaken)
                        pc_load = 1'b1;
                    else
                        pc_inc = 1'b1;
                    nxt = S_FETCH;
                end
                S_HALTED: begin
                    ack = 1'b1;
                    if (bus.Start) begin
                        pc_clr = 1'b1;
                        nxt    = S_FETCH;
                    end
                end
                S_ERR: err = 1'b1;
                default: nxt = S_IDLE;
            endcase
        end
    end

    assign bus.PCClr  = pc_clr;
    assign bus.IRLoad = ir_load;
    assign bus.PCInc  = pc_inc;
    assign bus.PCLoad = pc_load;
    assign bus.AccWE  = acc_we;
    assign bus.RegWE  = reg_we;
    assign bus.MemReq = mem_req;
    assign bus.MemWe  = mem_we;
    assign bus.Busy   = busy;
    assign bus.Ack    = ack;
    assign bus.Err    = err;

`ifdef PERF_COUNT_EN
    logic [15:0] cyc_cnt, inst_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else if (pc_clr) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            if (busy && cyc_cnt != 16'hFFFF)
                cyc_cnt <= cyc_cnt + 16'd1;
            if (inst_evt && inst_cnt != 16'hFFFF)
                inst_cnt <= inst_cnt + 16'd1;
        end
    end

    assign bus.CycleCnt = cyc_cnt;
    assign bus.InstCnt  = inst_cnt;
`else
    logic unused_evt;
    assign unused_evt = inst_evt;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomized instruction-stream bench for exec_sequencer: each instruction is expanded into its
// expected per-cycle strobe trace from the sequencing rules and compared cycle by cycle.
module tb_exec_sequencer;
    localparam int MEM_TO = 16;

    localparam logic [10:0] PCCLR = 11'h400, IRL  = 11'h200, PCINC = 11'h100, PCLD = 11'h080;
    localparam logic [10:0] ACC   = 11'h040, REGW = 11'h020, MREQ  = 11'h010, MWE  = 11'h008;
    localparam logic [10:0] BUSY  = 11'h004, ACK  = 11'h002, ERR   = 11'h001;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_cyc = 0;
    int   m_inst = 0;

    always #5 clk = ~clk;

    exec_sequencer_if bus ();

    exec_sequencer #(.MEM_TO(MEM_TO), .TO_W(5)) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    logic [10:0] outs;
    assign outs = {bus.PCClr, bus.IRLoad, bus.PCInc, bus.PCLoad, bus.AccWE, bus.RegWE,
                   bus.MemReq, bus.MemWe, bus.Busy, bus.Ack, bus.Err};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the counter model.
    task automatic tick(input string tag, input logic [10:0] want, input bit inst_evt);
        @(negedge clk);
        chk(tag, {21'd0, outs}, {21'd0, want});
`ifdef PERF_COUNT_EN
        chk({tag, "_cyc"}, {16'd0, bus.CycleCnt}, m_cyc);
        chk({tag, "_inst"}, {16'd0, bus.InstCnt}, m_inst);
`endif
        @(posedge clk);
        #1;
        if (want & PCCLR) begin
            m_cyc  = 0;
            m_inst = 0;
        end else begin
            if (want & BUSY) m_cyc++;
            if (inst_evt)    m_inst++;
        end
    endtask

    task automatic clear_dec();
        bus.RWrite = 0; bus.AWrite = 0; bus.Halt = 0; bus.Branch = 0;
        bus.ReadMem = 0; bus.WriteMem = 0; bus.BranchTaken = 0;
    endtask

    task automatic rand_dec();
        {bus.RWrite, bus.AWrite, bus.Halt, bus.Branch, bus.ReadMem, bus.WriteMem,
         bus.BranchTaken} = 7'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_outs", {21'd0, outs}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cyc  = 0;
        m_inst = 0;
    endtask

    initial begin
        int kind, d;
        bit is_sw;
        logic [10:0] wb;
        rst = 1'b1;
        bus.Start = 0;
        bus.MemRdy = 0;
        clear_dec();
        repeat (2) @(posedge clk);
        #1;
        chk("por_outs", {21'd0, outs}, 32'd0);
        rst = 1'b0;
        tick("idle", 11'h0, 0);
        bus.Start = 1;
        tick("start", PCCLR, 0);

        // Reset in the middle of a stalled load, with Start held high throughout.
        bus.Start = 0;
        rand_dec();
        tick("fetch0", IRL | BUSY, 0);
        clear_dec();
        bus.ReadMem = 1; bus.AWrite = 1;
        tick("exec0", BUSY, 0);
        bus.MemRdy = 0;
        tick("mem0", MREQ | BUSY, 0);
        tick("mem1", MREQ | BUSY, 0);
        bus.Start = 1;
        #2 rst = 1'b1;
        #1;
        chk("midmem_memreq", {31'd0, bus.MemReq}, 32'd0);
        chk("midmem_outs", {21'd0, outs}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cyc  = 0;
        m_inst = 0;
        tick("restart", PCCLR, 0);

        for (int k = 0; k < 300; k++) begin
            bus.Start  = 1'($urandom);
            bus.MemRdy = 1'($urandom);
            rand_dec();
            tick("fetch", IRL | BUSY, 0);

            kind = $urandom % 16;
            clear_dec();
            is_sw = 0;
            if (kind <= 4) begin
                bus.AWrite = 1'($urandom);
                bus.RWrite = 1'($urandom);
            end else if (kind <= 7) begin
                bus.ReadMem = 1; bus.AWrite = 1;
            end else if (kind <= 10) begin
                bus.WriteMem = 1; is_sw = 1;
            end else if (kind <= 13) begin
                bus.Branch = 1; bus.BranchTaken = 1'($urandom);
            end else if (kind == 14) begin
                bus.Halt = 1;
                bus.ReadMem = 1'($urandom);
                bus.AWrite = 1'($urandom);
            end else begin
                is_sw = 1'($urandom);
                bus.WriteMem = is_sw;
                bus.ReadMem = !is_sw;
                bus.AWrite = !is_sw;
            end
            bus.Start = 1'($urandom);
            tick("exec", BUSY, kind == 14);

            if (kind == 14) begin
                bus.Start = 0;
                repeat ($urandom_range(0, 3)) begin
                    bus.MemRdy = 1'($urandom);
                    tick("halted", ACK, 0);
                end
                bus.Start = 1;
                tick("halt_start", ACK | PCCLR, 0);
                continue;
            end

            if (bus.ReadMem || bus.WriteMem) begin
                if (kind == 15) d = MEM_TO;
                else if ($urandom % 8 == 0) d = MEM_TO - 1;
                else d = $urandom_range(0, 3);
                for (int i = 0; i < MEM_TO; i++) begin
                    bus.MemRdy = (i == d);
                    bus.Start = 1'($urandom);
                    tick("mem", MREQ | BUSY | (is_sw ? MWE : 11'h0), 0);
                    if (i == d) break;
                end
                if (d >= MEM_TO) begin
                    repeat ($urandom_range(1, 3)) begin
                        bus.Start = 1;
                        bus.MemRdy = 1'($urandom);
                        tick("err", ERR, 0);
                    end
                    do_reset();
                    bus.Start = 1;
                    tick("err_restart", PCCLR, 0);
                    continue;
                end
            end

            bus.Start = 1'($urandom);
            bus.MemRdy = 1'($urandom);
            wb = BUSY | (bus.AWrite ? ACC : 11'h0) | (bus.RWrite ? REGW : 11'h0)
                 | ((bus.Branch && bus.BranchTaken) ? PCLD : PCINC);
            tick("wb", wb, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
